// File: rtl/adc_mwr_tlp_gen_if.sv
// Transmit-side bundle between the ADC MWr generator and the 64b bridge.
// Master drives the TLP beats; slave returns grant, credit and beat-consume.
interface adc_mwr_tlp_gen_if;
  logic        tx64_req;
  logic        tx64_st;
  logic        tx64_end;
  logic        tx64_dwen;
  logic [63:0] tx64_data;
  logic        tx64_ph;
  logic [3:0]  tx64_pd;
  logic        credit_available;
  logic        tx64_rdy;
  logic        tx_val;

  modport master (
    output tx64_req, tx64_st, tx64_end, tx64_dwen,
    output tx64_data, tx64_ph, tx64_pd,
    input  credit_available, tx64_rdy, tx_val
  );

  modport slave (
    input  tx64_req, tx64_st, tx64_end, tx64_dwen,
    input  tx64_data, tx64_ph, tx64_pd,
    output credit_available, tx64_rdy, tx_val
  );
endinterface

// File: rtl/adc_mwr_tlp_gen.sv
// Packs ADC bytes into 64-bit words and streams them to a host ring
// buffer as 4DW-header posted Memory Write TLPs.
module adc_mwr_tlp_gen #(
  parameter int PAYLOAD_DW = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int BUF_BYTES  = 65536
) (
  input  logic        clk_125,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  adc_data,
  input  logic        adc_dv,
  input  logic [63:0] buf_base,
  input  logic [15:0] req_id,
  adc_mwr_tlp_gen_if.master tx,
  output logic        overflow,
  output logic [31:0] tlp_cnt,
  output logic [6:0]  fifo_level
);

  localparam int NW = PAYLOAD_DW / 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW = $clog2(BUF_BYTES);
  localparam int CW = $clog2(NW) + 1;
  localparam logic [AW-1:0] STEP = AW'(PAYLOAD_DW * 4);

  typedef enum logic [2:0] {
    IDLE, REQ, HDR0, HDR1, DATA
  } state_t;

  logic [2:0]  idx_q, idx_d;
  logic [63:0] pk_q, pk_d;
  logic [63:0] push_word;
  logic        push, full, wr, pop;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, rp_nx;
  logic [PW:0]   lvl_q, lvl_d;
  logic          ovf_q, ovf_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   data_q, data_d;
  logic          st_q, st_d;
  logic          end_q, end_d;
  logic [AW-1:0] off_q, off_d;
  logic [31:0]   tlp_q, tlp_d;

  logic [63:0] addr;
  logic [31:0] h0, h1;

  // Bytes shift in at the bottom so byte 0 ends up in [63:56].
  always_comb begin
    idx_d     = idx_q;
    pk_d      = pk_q;
    push      = 1'b0;
    push_word = {pk_q[55:0], adc_data};
    if (!enable) begin
      idx_d = 3'd0;
    end else if (adc_dv) begin
      pk_d  = push_word;
      idx_d = idx_q + 3'd1;
      push  = (idx_q == 3'd7);
    end
  end

  assign full  = (lvl_q == (PW+1)'(FIFO_DEPTH));
  assign wr    = push && !full;
  assign rp_nx = rp_q + PW'(1);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    lvl_d = lvl_q;
    ovf_d = ovf_q | (push && full);
    if (wr)  wp_d = wp_q + PW'(1);
    if (pop) rp_d = rp_nx;
    case ({wr, pop})
      2'b10:   lvl_d = lvl_q + (PW+1)'(1);
      2'b01:   lvl_d = lvl_q - (PW+1)'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  assign addr = buf_base | 64'(off_q);
  assign h0   = {8'h60, 14'd0, 10'(PAYLOAD_DW)};
  assign h1   = {req_id, 8'h00, 4'hF, 4'hF};

  // Beat registers are reloaded only when the current beat is consumed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    st_d    = st_q;
    end_d   = end_q;
    off_d   = off_q;
    tlp_d   = tlp_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && lvl_q >= (PW+1)'(NW)) state_d = REQ;
      end
      REQ: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tx.tx64_rdy && tx.credit_available) begin
          state_d = HDR0;
          data_d  = {h0, h1};
          st_d    = 1'b1;
        end
      end
      HDR0: begin
        if (tx.tx_val) begin
          state_d = HDR1;
          data_d  = {addr[63:32], addr[31:2], 2'b00};
          st_d    = 1'b0;
        end
      end
      HDR1: begin
        if (tx.tx_val) begin
          state_d = DATA;
          data_d  = mem[rp_q];
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (tx.tx_val) begin
          pop = 1'b1;
          if (cnt_q == CW'(NW - 1)) begin
            state_d = IDLE;
            data_d  = '0;
            end_d   = 1'b0;
            off_d   = off_q + STEP;
            if (tlp_q != 32'hFFFF_FFFF) tlp_d = tlp_q + 32'd1;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            data_d = mem[rp_nx];
            end_d  = (cnt_q == CW'(NW - 2));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_125) begin
    if (wr) mem[wp_q] <= push_word;
  end

  always_ff @(posedge clk_125) begin
    if (reset) begin
      idx_q   <= '0;
      pk_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      st_q    <= 1'b0;
      end_q   <= 1'b0;
      off_q   <= '0;
      tlp_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      pk_q    <= pk_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      st_q    <= st_d;
      end_q   <= end_d;
      off_q   <= off_d;
      tlp_q   <= tlp_d;
    end
  end

  assign tx.tx64_req  = (state_q == REQ);
  assign tx.tx64_ph   = (state_q == REQ);
  assign tx.tx64_st   = st_q;
  assign tx.tx64_end  = end_q;
  assign tx.tx64_data = data_q;
  assign tx.tx64_dwen = 1'b0;
  assign tx.tx64_pd   = 4'(PAYLOAD_DW / 4);

  assign overflow   = ovf_q;
  assign tlp_cnt    = tlp_q;
  assign fifo_level = 7'(lvl_q);

endmodule

// File: tb/tb_adc_mwr_tlp_gen.sv
// Randomized bench for adc_mwr_tlp_gen with a byte/TLP reference model.
// Uses a 256-byte ring so address wrap shows up within a few TLPs.
module tb_adc_mwr_tlp_gen;
  localparam int PDW   = 32;
  localparam int DEPTH = 64;
  localparam int BUFB  = 256;
  localparam int NW    = PDW / 2;
  localparam int NB    = NW + 2;

  logic        clk_125 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  adc_data = 8'h00;
  logic        adc_dv = 1'b0;
  logic [63:0] buf_base = '0;
  logic [15:0] req_id = '0;
  logic        overflow;
  logic [31:0] tlp_cnt;
  logic [6:0]  fifo_level;

  adc_mwr_tlp_gen_if tx();

  adc_mwr_tlp_gen #(
    .PAYLOAD_DW(PDW),
    .FIFO_DEPTH(DEPTH),
    .BUF_BYTES(BUFB)
  ) dut (
    .clk_125(clk_125),
    .reset(reset),
    .enable(enable),
    .adc_data(adc_data),
    .adc_dv(adc_dv),
    .buf_base(buf_base),
    .req_id(req_id),
    .tx(tx),
    .overflow(overflow),
    .tlp_cnt(tlp_cnt),
    .fifo_level(fifo_level)
  );

  always #4 clk_125 = ~clk_125;

  int checks = 0;
  int errors = 0;
  int duty = 100;

  logic [63:0] exp_w[$];
  logic [63:0] exp_b[$];
  logic [63:0] cap_d[$];
  bit          cap_s[$];
  bit          cap_e[$];
  bit          in_tlp = 1'b0;
  int          moff = 0;
  int          mtlp = 0;

  initial begin
    tx.tx_val = 1'b0;
    forever begin
      @(posedge clk_125);
      #1;
      tx.tx_val = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
    end
  end

  // Bridge-side view: record every beat consumed by a tx_val.
  always @(negedge clk_125) begin
    if (reset) begin
      in_tlp = 1'b0;
    end else if (tx.tx_val && (in_tlp || tx.tx64_st)) begin
      cap_d.push_back(tx.tx64_data);
      cap_s.push_back(tx.tx64_st);
      cap_e.push_back(tx.tx64_end);
      in_tlp = !tx.tx64_end;
    end
  end

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  task automatic clear_model();
    exp_w.delete();
    exp_b.delete();
    cap_d.delete();
    cap_s.delete();
    cap_e.delete();
    moff = 0;
    mtlp = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adc_dv = i[0];
      adc_data = 8'($urandom);
      tick();
    end
    adc_dv = 1'b0;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic send_bytes(input int n, input bit rnd, input bit gaps);
    logic [63:0] w;
    logic [7:0]  b;
    int k;
    int i;
    w = '0;
    k = 0;
    i = 0;
    while (i < n) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        adc_dv = 1'b0;
        tick();
      end else begin
        b = rnd ? 8'($urandom) : 8'(i);
        adc_data = b;
        adc_dv = 1'b1;
        w[63 - 8*k -: 8] = b;
        k++;
        if (k == 8) begin
          exp_w.push_back(w);
          k = 0;
        end
        i++;
        tick();
      end
    end
    adc_dv = 1'b0;
  endtask

  task automatic model_tlp();
    logic [63:0] a;
    a = buf_base | 64'(moff);
    exp_b.push_back({8'h60, 14'd0, 10'(PDW), req_id, 8'h00, 8'hFF});
    exp_b.push_back({a[63:2], 2'b00});
    for (int i = 0; i < NW; i++) exp_b.push_back(exp_w.pop_front());
    moff = (moff + PDW * 4) % BUFB;
    mtlp++;
  endtask

  task automatic wait_beats(input int n, input int budget, input string nm);
    for (int i = 0; i < budget && cap_d.size() < n; i++) tick();
    checks++;
    if (cap_d.size() < n) begin
      errors++;
      $display("FAIL %s timeout beats got %0d want %0d", nm, cap_d.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adc_dv = ~adc_dv;
      adc_data = 8'($urandom);
      enable = 1'b1;
      tick();
    end
    checks++;
    if ({tx.tx64_req, tx.tx64_st, tx.tx64_end, tx.tx64_dwen, tx.tx64_ph}
        !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 00000",
               {tx.tx64_req, tx.tx64_st, tx.tx64_end, tx.tx64_dwen, tx.tx64_ph});
    end
    checks++;
    if (tx.tx64_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", tx.tx64_data);
    end
    checks++;
    if (fifo_level !== 7'd0 || overflow !== 1'b0 || tlp_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stat got lvl %0d ovf %b cnt %0d want 0 0 0",
               fifo_level, overflow, tlp_cnt);
    end
    checks++;
    if (tx.tx64_pd !== 4'd8) begin
      errors++;
      $display("FAIL reset_pd got %0d want 8", tx.tx64_pd);
    end
    adc_dv = 1'b0;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_single_tlp();
    do_reset();
    buf_base = 64'h0000_0001_2000_0000;
    req_id = 16'h0100;
    enable = 1'b1;
    tx.tx64_rdy = 1'b1;
    tx.credit_available = 1'b1;
    duty = 100;
    send_bytes(128, 1'b0, 1'b0);
    model_tlp();
    wait_beats(NB, 200, "single");
    checks++;
    if (cap_d[0] !== 64'h6000_0020_0100_00FF) begin
      errors++;
      $display("FAIL single_beat0 got %h want 6000002001000_0ff", cap_d[0]);
    end
    checks++;
    if (cap_d[1] !== 64'h0000_0001_2000_0000) begin
      errors++;
      $display("FAIL single_beat1 got %h want 0000000120000000", cap_d[1]);
    end
    checks++;
    if (cap_d[2] !== 64'h0001_0203_0405_0607) begin
      errors++;
      $display("FAIL single_beat2 got %h want 0001020304050607", cap_d[2]);
    end
    for (int j = 0; j < NB; j++) begin
      checks++;
      if (j >= cap_d.size() || cap_d[j] !== exp_b[j] ||
          cap_s[j] !== (j == 0) || cap_e[j] !== (j == NB - 1)) begin
        errors++;
        $display("FAIL single_beat%0d got %h want %h", j,
                 (j < cap_d.size()) ? cap_d[j] : 64'hx, exp_b[j]);
      end
    end
    checks++;
    if (tlp_cnt !== 32'(mtlp)) begin
      errors++;
      $display("FAIL single_cnt got %0d want %0d", tlp_cnt, mtlp);
    end
  endtask

  task automatic test_credit_stall();
    do_reset();
    buf_base = {32'($urandom), 32'($urandom)} & ~64'(BUFB - 1);
    req_id = 16'($urandom);
    enable = 1'b1;
    tx.tx64_rdy = 1'b1;
    tx.credit_available = 1'b0;
    duty = 100;
    send_bytes(128, 1'b1, 1'b0);
    model_tlp();
    repeat (10) tick();
    checks++;
    if (tx.tx64_req !== 1'b1 || tx.tx64_ph !== 1'b1 ||
        tx.tx64_st !== 1'b0 || cap_d.size() != 0) begin
      errors++;
      $display("FAIL stall_hold got req %b ph %b st %b beats %0d want 1 1 0 0",
               tx.tx64_req, tx.tx64_ph, tx.tx64_st, cap_d.size());
    end
    tx.credit_available = 1'b1;
    tick();
    checks++;
    if (tx.tx64_st !== 1'b1 || tx.tx64_req !== 1'b0 ||
        tx.tx64_data !== exp_b[0]) begin
      errors++;
      $display("FAIL stall_release got st %b req %b data %h want 1 0 %h",
               tx.tx64_st, tx.tx64_req, tx.tx64_data, exp_b[0]);
    end
    wait_beats(NB, 100, "stall");
    for (int j = 0; j < NB; j++) begin
      checks++;
      if (j >= cap_d.size() || cap_d[j] !== exp_b[j] ||
          cap_s[j] !== (j == 0) || cap_e[j] !== (j == NB - 1)) begin
        errors++;
        $display("FAIL stall_beat%0d got %h want %h", j,
                 (j < cap_d.size()) ? cap_d[j] : 64'hx, exp_b[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    buf_base = {32'($urandom), 32'($urandom)} & ~64'(BUFB - 1);
    req_id = 16'($urandom);
    tx.tx64_rdy = 1'b1;
    tx.credit_available = 1'b1;
    duty = 30;
    enable = 1'b1;
    send_bytes(3, 1'b1, 1'b0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    send_bytes(256, 1'b1, 1'b1);
    model_tlp();
    model_tlp();
    wait_beats(2 * NB, 3000, "bp");
    checks++;
    if (cap_d.size() != 2 * NB) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", cap_d.size(), 2 * NB);
    end
    for (int j = 0; j < 2 * NB; j++) begin
      checks++;
      if (j >= cap_d.size() || cap_d[j] !== exp_b[j] ||
          cap_s[j] !== (j % NB == 0) || cap_e[j] !== (j % NB == NB - 1)) begin
        errors++;
        $display("FAIL bp_beat%0d got %h want %h", j,
                 (j < cap_d.size()) ? cap_d[j] : 64'hx, exp_b[j]);
      end
    end
    duty = 100;
  endtask

  task automatic test_ring_wrap();
    int offs[3];
    offs = '{0, 128, 0};
    do_reset();
    buf_base = 64'h0000_0001_2000_0000;
    req_id = 16'h0100;
    enable = 1'b1;
    tx.tx64_rdy = 1'b1;
    tx.credit_available = 1'b1;
    duty = 100;
    send_bytes(384, 1'b1, 1'b0);
    for (int t = 0; t < 3; t++) model_tlp();
    wait_beats(3 * NB, 400, "wrap");
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (cap_d[t * NB + 1][31:0] !== 32'h2000_0000 + 32'(offs[t])) begin
        errors++;
        $display("FAIL wrap_h3_%0d got %h want %h", t,
                 cap_d[t * NB + 1][31:0], 32'h2000_0000 + 32'(offs[t]));
      end
    end
    for (int j = 0; j < 3 * NB; j++) begin
      checks++;
      if (j >= cap_d.size() || cap_d[j] !== exp_b[j]) begin
        errors++;
        $display("FAIL wrap_beat%0d got %h want %h", j,
                 (j < cap_d.size()) ? cap_d[j] : 64'hx, exp_b[j]);
      end
    end
    checks++;
    if (tlp_cnt !== 32'd3) begin
      errors++;
      $display("FAIL wrap_cnt got %0d want 3", tlp_cnt);
    end
  endtask

  task automatic test_overflow_reset();
    do_reset();
    enable = 1'b1;
    tx.tx64_rdy = 1'b0;
    tx.credit_available = 1'b1;
    duty = 100;
    send_bytes(DEPTH * 8 + 8, 1'b1, 1'b0);
    tick();
    checks++;
    if (overflow !== 1'b1 || fifo_level !== 7'(DEPTH)) begin
      errors++;
      $display("FAIL ovf_set got ovf %b lvl %0d want 1 %0d",
               overflow, fifo_level, DEPTH);
    end
    checks++;
    if (tx.tx64_req !== 1'b1 || tx.tx64_ph !== 1'b1) begin
      errors++;
      $display("FAIL ovf_req got req %b ph %b want 1 1", tx.tx64_req, tx.tx64_ph);
    end
    tx.tx64_rdy = 1'b1;
    wait_beats(4, 40, "ovf_start");
    reset = 1'b1;
    tick();
    checks++;
    if ({tx.tx64_req, tx.tx64_st, tx.tx64_end, tx.tx64_ph} !== 4'b0 ||
        tx.tx64_data !== 64'h0) begin
      errors++;
      $display("FAIL midreset_tx got ctl %b data %h want 0000 0",
               {tx.tx64_req, tx.tx64_st, tx.tx64_end, tx.tx64_ph}, tx.tx64_data);
    end
    checks++;
    if (overflow !== 1'b0 || fifo_level !== 7'd0 || tlp_cnt !== 32'd0 ||
        tx.tx64_pd !== 4'd8) begin
      errors++;
      $display("FAIL midreset_stat got ovf %b lvl %0d cnt %0d pd %0d want 0 0 0 8",
               overflow, fifo_level, tlp_cnt, tx.tx64_pd);
    end
    reset = 1'b0;
    clear_model();
  endtask

  initial begin
    tx.tx64_rdy = 1'b0;
    tx.credit_available = 1'b0;
    test_reset();
    test_single_tlp();
    test_credit_stall();
    test_backpressure();
    test_ring_wrap();
    test_overflow_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
